// File: rtl/if_stage_pkg.sv
// Shared constants and types for the if_stage fetch front end.
// Build option DELAY_SLOT_EN selects MIPS delay-slot behaviour in the IF/ID register.
package if_stage_pkg;

    localparam int          INST_W        = 32;
    localparam int          INST_ADDR_W   = 32;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_WORD = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_WORD = 32'h0000_0000;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;

    // What the IF/ID register does on the next rising edge.
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_HOLD   = 2'd2,
        IFID_EXC    = 2'd3
    } ifid_op_e;

    function automatic logic word_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its environment (controller, ID, ROM).
// master = the fetch stage itself; slave = everything around it.
interface if_stage_if #(
    parameter int ADDR_W = 32
);
    import if_stage_pkg::*;

    // Control from the pipeline controller and ID
    logic              stall_if;
    logic              stall_id;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;

    // Instruction ROM, combinational read
    logic [INST_W-1:0] rom_data;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;

    // IF/ID register towards decode
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_valid;
    logic              id_exc_adel;

    modport master (
        input  stall_if, stall_id, branch_flag, branch_target, flush, new_pc, rom_data,
        output rom_ce, rom_addr, id_pc, id_inst, id_valid, id_exc_adel
    );

    modport slave (
        output stall_if, stall_id, branch_flag, branch_target, flush, new_pc, rom_data,
        input  rom_ce, rom_addr, id_pc, id_inst, id_valid, id_exc_adel
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble / hold / load selection plus misaligned-fetch marking.
// Without DELAY_SLOT_EN a taken branch squashes the sequential fetch into a bubble.
module if_stage_if_id_reg
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              misaligned_i,
    input  logic              flush_i,
    input  logic              stall_if_i,
    input  logic              stall_id_i,
    input  logic              branch_flag_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic              id_exc_adel_o
);

    ifid_op_e          op;
    logic              squash;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              adel_q, adel_d;

`ifdef DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    assign squash = branch_flag_i;
`endif

    // Flush outranks every stall; a stalled IF with a free ID leaves a hole in ID.
    always_comb begin
        op = IFID_LOAD;
        if (!ce_i || flush_i) begin
            op = IFID_BUBBLE;
        end else if (stall_if_i) begin
            op = stall_id_i ? IFID_HOLD : IFID_BUBBLE;
        end else if (squash) begin
            op = IFID_BUBBLE;
        end else if (misaligned_i) begin
            op = IFID_EXC;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        case (op)
            IFID_LOAD: begin
                pc_d    = pc_i;
                inst_d  = inst_i;
                valid_d = ce_i;
                adel_d  = 1'b0;
            end
            IFID_EXC: begin
                pc_d    = pc_i;
                inst_d  = NOP_INST;
                valid_d = 1'b1;
                adel_d  = 1'b1;
            end
            IFID_BUBBLE: begin
                pc_d    = '0;
                inst_d  = NOP_INST;
                valid_d = 1'b0;
                adel_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
        end
    end

    assign id_pc_o       = pc_q;
    assign id_inst_o     = inst_q;
    assign id_valid_o    = valid_q;
    assign id_exc_adel_o = adel_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch front end: PC register, ROM addressing, misalignment detect, IF/ID register.
// DELAY_SLOT_EN (passed through to the IF/ID register) keeps the fetch after a taken branch.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_WORD[ADDR_W-1:0],
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_WORD
) (
    input  logic  clk,
    input  logic  rst,
    if_stage_if.master bus
);

    logic              ce_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misaligned;

    // Fetch is enabled one edge after reset release; the PC is held until then.
    always_comb begin
        pc_d = pc_q;
        if (ce_q == CHIP_ENABLE) begin
            if (bus.flush) begin
                pc_d = bus.new_pc;
            end else if (bus.stall_if) begin
                pc_d = pc_q;
            end else if (bus.branch_flag) begin
                pc_d = bus.branch_target;
            end else begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q <= CHIP_DISABLE;
            pc_q <= RESET_PC;
        end else begin
            ce_q <= CHIP_ENABLE;
            pc_q <= pc_d;
        end
    end

    assign misaligned   = ce_q && word_misaligned(pc_q[1:0]);
    assign bus.rom_ce   = ce_q;
    assign bus.rom_addr = pc_q;

    if_stage_if_id_reg #(
        .ADDR_W   (ADDR_W),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .ce_i          (ce_q),
        .pc_i          (pc_q),
        .inst_i        (bus.rom_data),
        .misaligned_i  (misaligned),
        .flush_i       (bus.flush),
        .stall_if_i    (bus.stall_if),
        .stall_id_i    (bus.stall_id),
        .branch_flag_i (bus.branch_flag),
        .id_pc_o       (bus.id_pc),
        .id_inst_o     (bus.id_inst),
        .id_valid_o    (bus.id_valid),
        .id_exc_adel_o (bus.id_exc_adel)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a fetch-level reference model compared on every falling edge,
// plus literal spot checks on each scenario. Honours DELAY_SLOT_EN.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef DELAY_SLOT_EN
    localparam bit SQUASH_ON_BRANCH = 1'b0;
`else
    localparam bit SQUASH_ON_BRANCH = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    if_stage_if #(.ADDR_W(32)) bus ();

    if_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: a recognisable non-NOP word per address.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + addr;
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what fetch address is live and what decode is holding.
    logic        m_ce;
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    logic        m_id_valid, m_id_adel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ce       <= 1'b0;
            m_pc       <= 32'h0;
            m_id_pc    <= 32'h0;
            m_id_inst  <= NOP;
            m_id_valid <= 1'b0;
            m_id_adel  <= 1'b0;
        end else begin
            m_ce <= 1'b1;
            if (m_ce) begin
                if (bus.flush)             m_pc <= bus.new_pc;
                else if (!bus.stall_if && bus.branch_flag) m_pc <= bus.branch_target;
                else if (!bus.stall_if)    m_pc <= m_pc + 32'd4;
            end
            if (!m_ce || bus.flush || (bus.stall_if && !bus.stall_id) ||
                (!bus.stall_if && bus.branch_flag && SQUASH_ON_BRANCH)) begin
                m_id_pc    <= 32'h0;
                m_id_inst  <= NOP;
                m_id_valid <= 1'b0;
                m_id_adel  <= 1'b0;
            end else if (!bus.stall_if) begin
                m_id_pc    <= m_pc;
                m_id_inst  <= (m_pc[1:0] != 2'b00) ? NOP : rom_word(m_pc);
                m_id_valid <= 1'b1;
                m_id_adel  <= (m_pc[1:0] != 2'b00);
            end
        end
    end

    always @(negedge clk) begin
        chk("m_rom_ce",   32'(bus.rom_ce),      32'(m_ce));
        chk("m_rom_addr", bus.rom_addr,         m_pc);
        chk("m_id_pc",    bus.id_pc,            m_id_pc);
        chk("m_id_inst",  bus.id_inst,          m_id_inst);
        chk("m_id_valid", 32'(bus.id_valid),    32'(m_id_valid));
        chk("m_id_adel",  32'(bus.id_exc_adel), 32'(m_id_adel));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_if      = 1'b0;
        bus.stall_id      = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = 32'h0;
        bus.flush         = 1'b0;
        bus.new_pc        = 32'h0;
    endtask

    initial begin
        idle();
        tick(); tick();
        chk("rst_rom_ce",   32'(bus.rom_ce),   32'h0);
        chk("rst_rom_addr", bus.rom_addr,      32'h0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
        chk("rst_id_inst",  bus.id_inst,       32'h0);
        chk("rst_id_pc",    bus.id_pc,         32'h0);

        rst = 1'b0;
        tick();
        chk("rel_rom_ce",   32'(bus.rom_ce),   32'h1);
        chk("rel_rom_addr", bus.rom_addr,      32'h0);
        chk("rel_id_valid", 32'(bus.id_valid), 32'h0);
        tick();
        chk("seq_addr4",    bus.rom_addr,      32'h4);
        chk("seq_id_inst0", bus.id_inst,       32'h1000_0000);
        chk("seq_id_valid", 32'(bus.id_valid), 32'h1);
        tick();
        chk("seq_addr8",    bus.rom_addr,      32'h8);
        chk("seq_id_inst4", bus.id_inst,       32'h1000_0004);

        // IF stalled, ID free: two bubbles at pc=8
        bus.stall_if = 1'b1;
        tick();
        chk("sif_addr_a",  bus.rom_addr,      32'h8);
        chk("sif_valid_a", 32'(bus.id_valid), 32'h0);
        tick();
        chk("sif_addr_b",  bus.rom_addr,      32'h8);
        chk("sif_valid_b", 32'(bus.id_valid), 32'h0);
        bus.stall_if = 1'b0;
        tick();
        chk("sif_rel_addr", bus.rom_addr, 32'hC);
        chk("sif_rel_pc",   bus.id_pc,    32'h8);
        chk("sif_rel_inst", bus.id_inst,  32'h1000_0008);

        // Both stalled at pc=C: everything frozen
        bus.stall_if = 1'b1;
        bus.stall_id = 1'b1;
        tick(); tick();
        chk("sboth_addr", bus.rom_addr, 32'hC);
        chk("sboth_pc",   bus.id_pc,    32'h8);
        chk("sboth_inst", bus.id_inst,  32'h1000_0008);
        idle();
        tick();
        chk("sboth_rel_addr", bus.rom_addr, 32'h10);
        chk("sboth_rel_pc",   bus.id_pc,    32'hC);

        // Taken branch at pc=0x10 to 0x40
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h40;
        tick();
        chk("br_addr", bus.rom_addr, 32'h40);
`ifdef DELAY_SLOT_EN
        chk("br_slot_pc",    bus.id_pc,         32'h10);
        chk("br_slot_valid", 32'(bus.id_valid), 32'h1);
`else
        chk("br_squash_valid", 32'(bus.id_valid), 32'h0);
`endif
        idle();
        tick();
        chk("br_next_addr", bus.rom_addr, 32'h44);
        chk("br_tgt_pc",    bus.id_pc,    32'h40);
        chk("br_tgt_inst",  bus.id_inst,  32'h1000_0040);

        // Flush beats stall_if and branch_flag
        bus.flush         = 1'b1;
        bus.new_pc        = 32'h20;
        bus.stall_if      = 1'b1;
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h80;
        tick();
        chk("fl_addr",  bus.rom_addr,      32'h20);
        chk("fl_valid", 32'(bus.id_valid), 32'h0);

        // Branch to a misaligned target
        idle();
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h3;
        tick();
        chk("mis_addr", bus.rom_addr, 32'h3);
        idle();
        tick();
        chk("mis_addr_next", bus.rom_addr,         32'h7);
        chk("mis_id_pc",     bus.id_pc,            32'h3);
        chk("mis_id_inst",   bus.id_inst,          32'h0);
        chk("mis_id_valid",  32'(bus.id_valid),    32'h1);
        chk("mis_adel",      32'(bus.id_exc_adel), 32'h1);
        tick();
        chk("mis_adv_addr", bus.rom_addr,         32'hB);
        chk("mis_adv_adel", 32'(bus.id_exc_adel), 32'h1);

        // Flush beats a plain branch
        bus.flush         = 1'b1;
        bus.new_pc        = 32'h100;
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h300;
        tick();
        chk("flbr_addr", bus.rom_addr,         32'h100);
        chk("flbr_adel", 32'(bus.id_exc_adel), 32'h0);
        idle();
        tick();
        chk("flbr_next_addr", bus.rom_addr, 32'h104);
        chk("flbr_id_pc",     bus.id_pc,    32'h100);

        // Asynchronous reset in the middle of a full stall
        bus.stall_if = 1'b1;
        bus.stall_id = 1'b1;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_rom_ce",   32'(bus.rom_ce),   32'h0);
        chk("arst_rom_addr", bus.rom_addr,      32'h0);
        chk("arst_id_valid", 32'(bus.id_valid), 32'h0);
        chk("arst_id_pc",    bus.id_pc,         32'h0);
        idle();
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("arst_rel_ce",   32'(bus.rom_ce), 32'h1);
        chk("arst_rel_addr", bus.rom_addr,    32'h0);

        // PC wraps modulo 2^32
        bus.flush  = 1'b1;
        bus.new_pc = 32'hFFFF_FFF8;
        tick();
        idle();
        tick();
        chk("wrap_fffc", bus.rom_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero",    bus.rom_addr, 32'h0);
        chk("wrap_id_inst", bus.id_inst,  32'h0FFF_FFFC);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
